// File: rtl/btn_pkg.sv
// Shared definitions for the button event detector slice.
//   btn_state_t        : FSM state encoding (ARM, IDLE, PRESSED, HELD)
//   BTN_LONG_CYCLES    : default hold duration that qualifies a long press
//   BTN_REPEAT_CYCLES  : default auto-repeat period while held
//   BTN_CNT_W          : default hold-timer width
package btn_pkg;

  typedef enum logic [1:0] {
    ARM     = 2'd0,
    IDLE    = 2'd1,
    PRESSED = 2'd2,
    HELD    = 2'd3
  } btn_state_t;

  localparam int BTN_LONG_CYCLES   = 25_000_000;
  localparam int BTN_REPEAT_CYCLES = 5_000_000;
  localparam int BTN_CNT_W         = 25;

endpackage

// File: rtl/btn_hold_timer.sv
// Hold timer for the button event detector.
// Ports:
//   clk    in            system clock
//   rst    in            asynchronous active-high reset
//   clear  in            synchronous clear (wins over enable)
//   enable in            count up by one this cycle
//   limit  in  CNT_W     runtime terminal value
//   match  out           high while the count equals limit
module btn_hold_timer
  import btn_pkg::*;
#(
  parameter int CNT_W = BTN_CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             enable,
  input  logic [CNT_W-1:0] limit,
  output logic             match
);

  logic [CNT_W-1:0] count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable) begin
      count <= count + CNT_W'(1);
    end
  end

  assign match = (count == limit);

endmodule

// File: rtl/btn_event_detector.sv
// Button event detector: turns a debounced, clk-synchronous button level
// into single-cycle press/release/click/long/repeat pulses, a held level
// and a wrapping 8-bit press counter.
// Optional feature macro: BTN_AUTOREPEAT_EN enables repeat_pulse while held.
// Ports:
//   clk            in      system clock
//   rst            in      asynchronous active-high reset
//   btn_in         in      debounced button level, 1 = pressed
//   press_pulse    out     one cycle on press
//   release_pulse  out     one cycle on release
//   click_pulse    out     one cycle on release before the long threshold
//   long_pulse     out     one cycle when the hold reaches LONG_CYCLES
//   repeat_pulse   out     one cycle every REPEAT_CYCLES while held past long
//   held           out     level, high in PRESSED or HELD
//   press_count    out  8  presses since reset, wraps 255 -> 0
module btn_event_detector
  import btn_pkg::*;
#(
  parameter int LONG_CYCLES   = BTN_LONG_CYCLES,
  parameter int REPEAT_CYCLES = BTN_REPEAT_CYCLES,
  parameter int CNT_W         = BTN_CNT_W
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_in,
  output logic       press_pulse,
  output logic       release_pulse,
  output logic       click_pulse,
  output logic       long_pulse,
  output logic       repeat_pulse,
  output logic       held,
  output logic [7:0] press_count
);

  btn_state_t       state;
  logic             timer_clear;
  logic             timer_enable;
  logic             timer_match;
  logic [CNT_W-1:0] timer_limit;

  // The timer compares against the repeat period once in HELD and the long
  // threshold otherwise; the limit only matters while the timer is enabled.
  assign timer_limit = (state == HELD) ? CNT_W'(REPEAT_CYCLES - 1)
                                       : CNT_W'(LONG_CYCLES - 1);

  // Timer is held at zero outside a press, and is cleared on release or on
  // a threshold hit so the next interval starts from zero.
  always_comb begin
    timer_clear  = 1'b1;
    timer_enable = 1'b0;
    case (state)
      PRESSED: begin
        if (btn_in && !timer_match) begin
          timer_clear  = 1'b0;
          timer_enable = 1'b1;
        end
      end
      HELD: begin
`ifdef BTN_AUTOREPEAT_EN
        if (btn_in && !timer_match) begin
          timer_clear  = 1'b0;
          timer_enable = 1'b1;
        end
`else
        if (btn_in) begin
          timer_clear  = 1'b0;
        end
`endif
      end
      default: begin
      end
    endcase
  end

  btn_hold_timer #(
    .CNT_W(CNT_W)
  ) u_timer (
    .clk   (clk),
    .rst   (rst),
    .clear (timer_clear),
    .enable(timer_enable),
    .limit (timer_limit),
    .match (timer_match)
  );

  // Main FSM with registered outputs. Pulses default low each cycle; the
  // release branch is tested first so it beats a same-cycle threshold hit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= ARM;
      press_pulse   <= 1'b0;
      release_pulse <= 1'b0;
      click_pulse   <= 1'b0;
      long_pulse    <= 1'b0;
      repeat_pulse  <= 1'b0;
      held          <= 1'b0;
      press_count   <= 8'd0;
    end else begin
      press_pulse   <= 1'b0;
      release_pulse <= 1'b0;
      click_pulse   <= 1'b0;
      long_pulse    <= 1'b0;
      repeat_pulse  <= 1'b0;
      case (state)
        ARM: begin
          // A button held through reset must be released before it counts.
          if (!btn_in) begin
            state <= IDLE;
          end
        end
        IDLE: begin
          if (btn_in) begin
            state       <= PRESSED;
            press_pulse <= 1'b1;
            held        <= 1'b1;
            press_count <= press_count + 8'd1;
          end
        end
        PRESSED: begin
          if (!btn_in) begin
            state         <= IDLE;
            release_pulse <= 1'b1;
            click_pulse   <= 1'b1;
            held          <= 1'b0;
          end else if (timer_match) begin
            state      <= HELD;
            long_pulse <= 1'b1;
          end
        end
        HELD: begin
          if (!btn_in) begin
            state         <= IDLE;
            release_pulse <= 1'b1;
            held          <= 1'b0;
          end
`ifdef BTN_AUTOREPEAT_EN
          else if (timer_match) begin
            repeat_pulse <= 1'b1;
          end
`endif
        end
        default: begin
          state <= ARM;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_btn_event_detector.sv
// Self-checking bench for btn_event_detector with LONG_CYCLES=10 and
// REPEAT_CYCLES=4. Expected output vectors are queued as each btn_in level
// is driven and popped when the following posedge result is sampled.
// Vector layout: {press, release, click, long, repeat, held, press_count}.
module tb_btn_event_detector;
  import btn_pkg::*;

  localparam int LONG   = 10;
  localparam int REPEAT = 4;

  logic       clk;
  logic       rst;
  logic       btn_in;
  logic       press_pulse;
  logic       release_pulse;
  logic       click_pulse;
  logic       long_pulse;
  logic       repeat_pulse;
  logic       held;
  logic [7:0] press_count;

  int         total;
  int         bad;
  logic [7:0] cnt;
  logic [12:0] exp_q[$];

  btn_event_detector #(
    .LONG_CYCLES  (LONG),
    .REPEAT_CYCLES(REPEAT),
    .CNT_W        (8)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .btn_in       (btn_in),
    .press_pulse  (press_pulse),
    .release_pulse(release_pulse),
    .click_pulse  (click_pulse),
    .long_pulse   (long_pulse),
    .repeat_pulse (repeat_pulse),
    .held         (held),
    .press_count  (press_count)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1);
  end

  function automatic logic [12:0] obs();
    return {press_pulse, release_pulse, click_pulse, long_pulse,
            repeat_pulse, held, press_count};
  endfunction

  // Expected vector k cycles after the press edge, for a press lasting w
  // cycles that started with count c, derived from the event timing rules.
  function automatic logic [12:0] exp_at(int k, int w, logic [7:0] c);
    logic p, r, cl, l, rp, h;
    p  = (k == 0);
    r  = (k == w);
    cl = (k == w) && (w <= LONG);
    l  = (k == LONG) && (w > LONG);
    rp = 1'b0;
`ifdef BTN_AUTOREPEAT_EN
    if (k > LONG && k < w && ((k - LONG) % REPEAT) == 0) rp = 1'b1;
`endif
    h  = (k < w);
    return {p, r, cl, l, rp, h, c + 8'd1};
  endfunction

  task automatic test_reset();
    logic [12:0] o;
    rst    = 1'b1;
    btn_in = 1'b1;
    repeat (3) @(negedge clk);
    o = obs();
    total++;
    if (o !== 13'd0) begin
      bad++;
      $display("[TB] FAIL reset got=%h want=%h", o, 13'd0);
    end
    cnt = 8'd0;
  endtask

  task automatic test_arm();
    logic [12:0] o, e;
    rst = 1'b0;
    for (int k = 0; k < 5; k++) begin
      btn_in = (k < 3);
      exp_q.push_back(13'd0);
      @(posedge clk); @(negedge clk);
      o = obs(); e = exp_q.pop_front();
      total++;
      if (o !== e) begin
        bad++;
        $display("[TB] FAIL arm k=%0d got=%h want=%h", k, o, e);
      end
    end
    for (int k = 0; k < 5; k++) begin
      btn_in = (k < 3);
      exp_q.push_back(exp_at(k, 3, cnt));
      @(posedge clk); @(negedge clk);
      o = obs(); e = exp_q.pop_front();
      total++;
      if (o !== e) begin
        bad++;
        $display("[TB] FAIL arm_press k=%0d got=%h want=%h", k, o, e);
      end
    end
    cnt = cnt + 8'd1;
  endtask

  task automatic test_click();
    logic [12:0] o, e;
    for (int k = 0; k < 5; k++) begin
      btn_in = (k < 3);
      exp_q.push_back(exp_at(k, 3, cnt));
      @(posedge clk); @(negedge clk);
      o = obs(); e = exp_q.pop_front();
      total++;
      if (o !== e) begin
        bad++;
        $display("[TB] FAIL click k=%0d got=%h want=%h", k, o, e);
      end
    end
    cnt = cnt + 8'd1;
  endtask

  task automatic test_long_hold();
    logic [12:0] o, e;
    for (int k = 0; k < 22; k++) begin
      btn_in = (k < 20);
      exp_q.push_back(exp_at(k, 20, cnt));
      @(posedge clk); @(negedge clk);
      o = obs(); e = exp_q.pop_front();
      total++;
      if (o !== e) begin
        bad++;
        $display("[TB] FAIL long_hold k=%0d got=%h want=%h", k, o, e);
      end
    end
    cnt = cnt + 8'd1;
  endtask

  task automatic test_release_at_threshold();
    logic [12:0] o, e;
    for (int k = 0; k < LONG + 2; k++) begin
      btn_in = (k < LONG);
      exp_q.push_back(exp_at(k, LONG, cnt));
      @(posedge clk); @(negedge clk);
      o = obs(); e = exp_q.pop_front();
      total++;
      if (o !== e) begin
        bad++;
        $display("[TB] FAIL threshold k=%0d got=%h want=%h", k, o, e);
      end
    end
    cnt = cnt + 8'd1;
  endtask

  task automatic test_back_to_back();
    logic [12:0] o, e;
    for (int n = 0; n < 3; n++) begin
      for (int k = 0; k < 2; k++) begin
        btn_in = (k == 0);
        exp_q.push_back(exp_at(k, 1, cnt));
        @(posedge clk); @(negedge clk);
        o = obs(); e = exp_q.pop_front();
        total++;
        if (o !== e) begin
          bad++;
          $display("[TB] FAIL b2b n=%0d k=%0d got=%h want=%h", n, k, o, e);
        end
      end
      cnt = cnt + 8'd1;
    end
  endtask

  task automatic test_wrap();
    logic [12:0] o, e;
    rst    = 1'b1;
    btn_in = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    cnt = 8'd0;
    exp_q.push_back(13'd0);
    @(posedge clk); @(negedge clk);
    o = obs(); e = exp_q.pop_front();
    total++;
    if (o !== e) begin
      bad++;
      $display("[TB] FAIL wrap_arm got=%h want=%h", o, e);
    end
    for (int n = 0; n < 256; n++) begin
      for (int k = 0; k < 2; k++) begin
        btn_in = (k == 0);
        exp_q.push_back(exp_at(k, 1, cnt));
        @(posedge clk); @(negedge clk);
        o = obs(); e = exp_q.pop_front();
        total++;
        if (o !== e) begin
          bad++;
          $display("[TB] FAIL wrap n=%0d k=%0d got=%h want=%h", n, k, o, e);
        end
      end
      cnt = cnt + 8'd1;
    end
    total++;
    if (press_count !== 8'd0) begin
      bad++;
      $display("[TB] FAIL wrap_zero got=%0d want=0", press_count);
    end
  endtask

  task automatic test_reset_mid_hold();
    logic [12:0] o, e;
    for (int k = 0; k <= LONG; k++) begin
      btn_in = 1'b1;
      exp_q.push_back(exp_at(k, 100, cnt));
      @(posedge clk); @(negedge clk);
      o = obs(); e = exp_q.pop_front();
      total++;
      if (o !== e) begin
        bad++;
        $display("[TB] FAIL mid_hold k=%0d got=%h want=%h", k, o, e);
      end
    end
    // long_pulse is high right now; reset must cut it without a clock edge
    rst = 1'b1;
    #1;
    o = obs();
    total++;
    if (o !== 13'd0) begin
      bad++;
      $display("[TB] FAIL async_reset got=%h want=%h", o, 13'd0);
    end
    total++;
    if (dut.state !== ARM) begin
      bad++;
      $display("[TB] FAIL reset_state got=%0d want=%0d", dut.state, ARM);
    end
    @(negedge clk);
    rst = 1'b0;
    cnt = 8'd0;
    for (int k = 0; k < 4; k++) begin
      btn_in = (k < 3);
      exp_q.push_back(13'd0);
      @(posedge clk); @(negedge clk);
      o = obs(); e = exp_q.pop_front();
      total++;
      if (o !== e) begin
        bad++;
        $display("[TB] FAIL rearm k=%0d got=%h want=%h", k, o, e);
      end
    end
    for (int k = 0; k < 3; k++) begin
      btn_in = (k < 2);
      exp_q.push_back(exp_at(k, 2, cnt));
      @(posedge clk); @(negedge clk);
      o = obs(); e = exp_q.pop_front();
      total++;
      if (o !== e) begin
        bad++;
        $display("[TB] FAIL rearm_press k=%0d got=%h want=%h", k, o, e);
      end
    end
    cnt = cnt + 8'd1;
  endtask

  initial begin
    total  = 0;
    bad    = 0;
    cnt    = 8'd0;
    rst    = 1'b1;
    btn_in = 1'b0;
    test_reset();
    test_arm();
    test_click();
    test_long_hold();
    test_release_at_threshold();
    test_back_to_back();
    test_wrap();
    test_reset_mid_hold();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
